vga_dot_serializer: RTL and testbench

Parallel-to-serial dot shifter that drives the serial pixel input of the pixel panning stage. Accepts one 32-bit character fetch (four plane bytes) through a valid/ready handshake, double-buffers it, and emits one 4-bit dot per dot-clock enable in planar, interleaved (odd/even) or 256-colour packed order, with optional 9-dot character cells. Sits between the memory-latch/attribute-fetch logic and the pixel panning shift chain, one lane per plane bit.

---
 rtl/vga_dot_serializer.sv | 173 +++++++++++++++++
 tb/tb_vga_dot_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dot_serializer.sv
// vga_dot_serializer
// Parallel-to-serial dot shifter feeding the pixel panning stage. A 32-bit
// character fetch {plane3,plane2,plane1,plane0} is accepted into a hold
// buffer through a valid/ready handshake and moved into the active register
// at a character boundary. One 4-bit dot (bit p = plane p) is emitted per
// dot-clock enable in planar, interleaved or 256-colour packed order.
//
// Ports:
//   clk, reset             dot clock, synchronous active-high reset
//   clk_en                 dot clock enable (dot index / outputs advance)
//   ser_en                 serializer enable, sampled at character boundaries
//   shift_mode[1:0]        00 planar, 01 interleaved, 1x packed
//   char_9dot, dot9_dup    9-dot cell (planar), dot 8 repeats dot 7
//   ld_valid, ld_ready     fetch handshake (ready = hold buffer empty)
//   ld_data[31:0]          fetch word
//   dout[3:0], dout_valid  serial dot and its validity
//   char_start             pulse when dot 0 of a cell is emitted (including
//                          the zero-filled cell that follows an underrun)
//   underrun               sticky: boundary reached with hold buffer empty
module vga_dot_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        ser_en,
  input  logic [1:0]  shift_mode,
  input  logic        char_9dot,
  input  logic        dot9_dup,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  output logic [3:0]  dout,
  output logic        dout_valid,
  output logic        char_start,
  output logic        underrun
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_data;
  logic        hold_full;
  logic [31:0] act_data;
  logic [1:0]  act_mode;
  logic        act_9dot, act_dup, act_valid;
  logic [3:0]  idx, idx_nxt, last_idx;
  logic        transfer, starve, accept;
  logic [3:0]  pixel;

  logic [7:0]  p0, p1, p2, p3, ia, ib, pk;
  logic [2:0]  bpos, ihi, ilo;

  // hold_full is a register, so ready is a registered flag with no input path
  assign ld_ready = ~hold_full;
  assign accept   = ld_valid & ~hold_full;
  assign last_idx = (act_9dot && act_mode == 2'b00) ? 4'd8 : 4'd7;

  assign p0 = act_data[7:0];
  assign p1 = act_data[15:8];
  assign p2 = act_data[23:16];
  assign p3 = act_data[31:24];

  // Next-state / sequencing decisions
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    transfer  = 1'b0;
    starve    = 1'b0;
    if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (ser_en && hold_full) begin
            transfer  = 1'b1;
            idx_nxt   = '0;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (idx == last_idx) begin
            idx_nxt = '0;
            if (!ser_en)       state_nxt = S_IDLE;
            else if (hold_full) transfer = 1'b1;
            else                starve   = 1'b1;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Dot selection from the active word
  always_comb begin
    pixel = '0;
    bpos  = 3'd7 - idx[2:0];
    ihi   = 3'd7 - {idx[1:0], 1'b0};
    ilo   = 3'd6 - {idx[1:0], 1'b0};
    ia    = idx[2] ? p1 : p0;
    ib    = idx[2] ? p3 : p2;
    case (idx[2:1])
      2'd0:    pk = p0;
      2'd1:    pk = p1;
      2'd2:    pk = p2;
      default: pk = p3;
    endcase
    if (act_mode[1]) begin
      pixel = idx[0] ? pk[3:0] : pk[7:4];
    end else if (act_mode[0]) begin
      pixel = {ib[ihi], ib[ilo], ia[ihi], ia[ilo]};
    end else if (idx[3]) begin
      // ninth dot: copy of dot 7 (bit 0 of each plane) or blank
      pixel = act_dup ? {p3[0], p2[0], p1[0], p0[0]} : '0;
    end else begin
      pixel = {p3[bpos], p2[bpos], p1[bpos], p0[bpos]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      act_data   <= '0;
      act_mode   <= '0;
      act_9dot   <= 1'b0;
      act_dup    <= 1'b0;
      act_valid  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      char_start <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;

      // transfer needs hold_full and accept needs it clear: never both
      if (transfer) hold_full <= 1'b0;
      if (accept) begin
        hold_data <= ld_data;
        hold_full <= 1'b1;
      end

      if (transfer) begin
        act_data  <= hold_data;
        act_mode  <= shift_mode;
        act_9dot  <= char_9dot;
        act_dup   <= dot9_dup;
        act_valid <= 1'b1;
      end else if (starve) begin
        act_data  <= '0;
        act_mode  <= '0;
        act_9dot  <= 1'b0;
        act_dup   <= 1'b0;
        act_valid <= 1'b0;
        underrun  <= 1'b1;
      end

      char_start <= 1'b0;
      if (clk_en) begin
        if (state == S_RUN) begin
          dout       <= pixel;
          dout_valid <= act_valid;
          char_start <= (idx == 4'd0);
        end else begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_dot_serializer.sv
module tb_vga_dot_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        ser_en = 1'b0;
  logic [1:0]  shift_mode = 2'b00;
  logic        char_9dot = 1'b0;
  logic        dot9_dup = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, dout_valid, char_start, underrun;
  logic [3:0]  dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_dot_serializer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .ser_en(ser_en),
    .shift_mode(shift_mode), .char_9dot(char_9dot), .dot9_dup(dot9_dup),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .dout(dout), .dout_valid(dout_valid), .char_start(char_start),
    .underrun(underrun)
  );

  // Record of valid dots: dot value, char_start, underrun after the edge,
  // and the running count of clk_en edges (to prove continuity).
  typedef struct {
    logic [3:0] d;
    logic       cs;
    logic       un;
    int         ce_n;
  } rec_t;
  rec_t vq[$];
  int   ce_n = 0;

  // Reference dot for word w, mode m, position n, computed from bit positions
  function automatic logic [3:0] ref_pix(logic [31:0] w, logic [1:0] m, logic dup, int n);
    logic [3:0]  r;
    logic [31:0] t;
    int j, a, b, nn, byte_v;
    r = '0;
    if (m[1]) begin
      byte_v = int'((w >> (8 * (n / 2))) & 32'hFF);
      r = (n % 2 == 0) ? 4'(byte_v / 16) : 4'(byte_v % 16);
    end else if (m[0]) begin
      j = n % 4;
      a = (n < 4) ? 0 : 8;
      b = a + 16;
      t = w >> (b + 7 - 2 * j); r[3] = t[0];
      t = w >> (b + 6 - 2 * j); r[2] = t[0];
      t = w >> (a + 7 - 2 * j); r[1] = t[0];
      t = w >> (a + 6 - 2 * j); r[0] = t[0];
    end else begin
      nn = (n == 8) ? 7 : n;
      for (int p = 0; p < 4; p++) begin
        t = w >> (8 * p + 7 - nn);
        r[p] = t[0];
      end
      if (n == 8 && !dup) r = '0;
    end
    return r;
  endfunction

  // Behavioural model state
  bit          m_live = 0;
  bit          m_run, m_full, m_9, m_dup, m_valid, m_dv, m_cs, m_un;
  int          m_pos;
  logic [31:0] m_word, m_hold;
  logic [1:0]  m_mode;
  logic [3:0]  m_dout;

  logic        s_rst, s_ce, s_se, s_c9, s_dup, s_lv;
  logic [1:0]  s_sm;
  logic [31:0] s_ld;
  bit          pre_full, load_now;
  int          cell_len;

  always @(posedge clk) begin
    s_rst = reset; s_ce = clk_en; s_se = ser_en; s_c9 = char_9dot;
    s_dup = dot9_dup; s_lv = ld_valid; s_sm = shift_mode; s_ld = ld_data;
    if (s_rst) begin
      m_live = 1; m_run = 0; m_pos = 0; m_word = '0; m_mode = '0; m_9 = 0;
      m_dup = 0; m_valid = 0; m_full = 0; m_hold = '0; m_dout = '0;
      m_dv = 0; m_cs = 0; m_un = 0;
    end else if (m_live) begin
      pre_full = m_full;
      load_now = 0;
      if (s_ce) begin
        ce_n++;
        if (!m_run) begin
          m_dout = '0; m_dv = 0; m_cs = 0;
          if (s_se && pre_full) begin load_now = 1; m_run = 1; end
        end else begin
          m_dout = ref_pix(m_word, m_mode, m_dup, m_pos);
          m_dv = m_valid;
          m_cs = (m_pos == 0);
          cell_len = (m_9 && m_mode == 2'b00) ? 9 : 8;
          if (m_pos == cell_len - 1) begin
            m_pos = 0;
            if (!s_se) m_run = 0;
            else if (pre_full) load_now = 1;
            else begin
              m_word = '0; m_mode = '0; m_9 = 0; m_dup = 0; m_valid = 0; m_un = 1;
            end
          end else begin
            m_pos++;
          end
        end
      end else begin
        m_cs = 0;
      end
      if (load_now) begin
        m_word = m_hold; m_mode = s_sm; m_9 = s_c9; m_dup = s_dup;
        m_valid = 1; m_pos = 0; m_full = 0;
      end
      if (s_lv && !pre_full) begin
        m_hold = s_ld; m_full = 1;
      end
    end
    #1;
    if (m_live) begin
      checks++;
      if ({dout, dout_valid, char_start, underrun, ld_ready} !==
          {m_dout, m_dv, m_cs, m_un, !m_full}) begin
        failures++;
        $display("FAIL model t=%0t got dout=%h dv=%b cs=%b un=%b rdy=%b exp dout=%h dv=%b cs=%b un=%b rdy=%b",
                 $time, dout, dout_valid, char_start, underrun, ld_ready,
                 m_dout, m_dv, m_cs, m_un, !m_full);
      end
      if (s_ce && !s_rst && dout_valid)
        vq.push_back('{d: dout, cs: char_start, un: underrun, ce_n: ce_n});
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; clk_en = 0; ser_en = 0; ld_valid = 0;
    step();
    reset = 0;
  endtask

  // Load one word, then run clk_en=1 ser_en=1 for n cycles
  task automatic run_char(logic [31:0] w, logic [1:0] m, logic c9, logic dp, int n);
    do_reset();
    shift_mode = m; char_9dot = c9; dot9_dup = dp;
    ld_data = w; ld_valid = 1; ser_en = 1; clk_en = 1;
    vq.delete();
    step();
    ld_valid = 0;
    step(n);
  endtask

  int          pk[8] = '{1, 0, 3, 2, 5, 4, 7, 6};
  int          il[8] = '{3, 2, 1, 0, 0, 0, 0, 0};
  logic [7:0]  a5;
  bit          drop;
  int          waited;

  initial begin
    step();
    reset = 0;
    // reset values
    chk("reset_state", {28'h0, dout, dout_valid, char_start, underrun, ld_ready},
        {28'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});

    // planar 00_00_FF_A5
    a5 = 8'hA5;
    run_char(32'h0000_FFA5, 2'b00, 0, 0, 14);
    chk("planar_len", vq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("planar_dot%0d", i), {28'h0, vq[i].d}, {28'h0, 2'b00, 1'b1, a5[7 - i]});
      chk($sformatf("planar_cs%0d", i), vq[i].cs, (i == 0));
    end
    chk("underrun_set", {30'h0, underrun, dout_valid}, {30'h0, 2'b10});
    step(5);
    chk("underrun_sticky", underrun, 1);
    do_reset();
    chk("underrun_reset", {30'h0, underrun, ld_ready}, {30'h0, 2'b01});

    // 9-dot cells
    run_char(32'h0000_0001, 2'b00, 1, 1, 14);
    chk("dot9_len", vq.size(), 9);
    chk("dot9_dup_on", vq[8].d[0], 1);
    chk("dot9_span", vq[8].ce_n - vq[0].ce_n, 8);
    run_char(32'h0000_0001, 2'b00, 1, 0, 14);
    chk("dot9_dup_off", {28'h0, vq[8].d}, 0);
    chk("dot9_dot7", vq[7].d[0], 1);

    // packed
    run_char(32'h7654_3210, 2'b10, 0, 0, 14);
    chk("packed_len", vq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("packed_dot%0d", i), {28'h0, vq[i].d}, pk[i]);

    // interleaved
    run_char(32'h0000_00E4, 2'b01, 0, 0, 14);
    chk("inter_len", vq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("inter_dot%0d", i), {28'h0, vq[i].d}, il[i]);

    // two words early, clk_en every other clock
    do_reset();
    shift_mode = 2'b00; char_9dot = 0; dot9_dup = 0;
    ld_data = 32'hC3A5_0FF0; ld_valid = 1;
    vq.delete();
    step();
    ld_data = 32'h5A3C_F00F;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ready_low_wait", ld_ready, 0);
    end
    ser_en = 1; clk_en = 0; drop = 0;
    for (int i = 0; i < 44; i++) begin
      if (drop) ld_valid = 0;
      drop = ld_valid && ld_ready;
      clk_en = ~clk_en;
      step();
    end
    chk("b2b_len", vq.size(), 16);
    chk("b2b_contig", vq[15].ce_n - vq[0].ce_n, 15);
    chk("b2b_no_underrun", {vq[7].un, vq[14].un}, 0);
    chk("b2b_second_cs", vq[8].cs, 1);

    // reset mid-character
    do_reset();
    ld_data = 32'hFFFF_FFFF; ld_valid = 1; ser_en = 1; clk_en = 1;
    vq.delete();
    step();
    ld_valid = 0;
    step();
    ld_data = 32'h1234_5678; ld_valid = 1;
    step();
    ld_valid = 0;
    waited = 0;
    while (vq.size() < 5 && waited < 20) begin
      step();
      waited++;
    end
    chk("mid_reached_dot4", vq.size() >= 5, 1);
    chk("mid_ready_low", ld_ready, 0);
    reset = 1;
    step();
    chk("mid_reset", {28'h0, dout, dout_valid, ld_ready, underrun},
        {28'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    reset = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      clk_en     = ($urandom_range(0, 9) < 7);
      ser_en     = ($urandom_range(0, 19) != 0);
      ld_valid   = 1'($urandom_range(0, 1));
      ld_data    = $urandom;
      shift_mode = 2'($urandom_range(0, 3));
      char_9dot  = 1'($urandom_range(0, 1));
      dot9_dup   = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
